// File: rtl/cache_arbiter.sv
// Arbitrates the single physical-memory port between the I-cache and D-cache,
// one line transaction at a time. Define CACHE_ARB_RR_EN for round-robin on conflict.
module cache_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  d_req;
    logic                  d_wins;

    assign d_req = d_read | d_write;

`ifdef CACHE_ARB_RR_EN
    // High when the most recent grant went to the D-cache; resets to I so the first conflict goes to D.
    logic last_d_q, last_d_d;
    assign d_wins = ~last_d_q;
`else
    assign d_wins = 1'b1;
`endif

    // Next-state, grant and latch selection.
    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef CACHE_ARB_RR_EN
        last_d_d    = last_d_q;
`endif
        case (state_q)
            IDLE: begin
                if (d_req && (!i_read || d_wins)) begin
                    state_d     = SERVE_D;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    // A write-back wins over a read if a D-cache ever raises both.
                    mem_write_d = d_write;
                    mem_read_d  = ~d_write;
`ifdef CACHE_ARB_RR_EN
                    last_d_d    = 1'b1;
`endif
                end else if (i_read) begin
                    state_d     = SERVE_I;
                    mem_addr_d  = i_addr;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
`ifdef CACHE_ARB_RR_EN
                    last_d_d    = 1'b0;
`endif
                end else begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    state_d     = IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end else begin
                    state_d     = state_q;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    // Controller state and registered memory-port outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef CACHE_ARB_RR_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef CACHE_ARB_RR_EN
            last_d_q    <= last_d_d;
`endif
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Response is combinational from mem_resp so the requester sees completion in the same cycle.
    assign i_resp  = (state_q == SERVE_I) & mem_resp;
    assign d_resp  = (state_q == SERVE_D) & mem_resp;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule
